alu_arbiter: RTL and testbench

//  Shares one combinational ALU (32-bit A/B; add/inc/neg/sub control lines; out, Z, N) between NREQ requesters.

---
 rtl/alu_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcode constants and FSM state encoding for the ALU arbiter
//
// Purpose: shared definitions for alu_arbiter and its round-robin helper.
//   OP_*   : 2-bit request opcodes carried on req_op
//   state_t: arbiter FSM states (IDLE -> EXEC -> RESP)
package alu_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selector
//
// Purpose: picks the first set request bit, searching upward from i_ptr+1
//   (mod NREQ), so the last winner held in i_ptr has lowest priority.
// Ports:
//   i_req   [NREQ-1:0] request vector
//   i_ptr   [IDW-1:0]  index of the most recent winner
//   o_grant [NREQ-1:0] one-hot grant, zero when no request is set
//   o_idx   [IDW-1:0]  encoded index of the granted requester
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);

  logic w_found;

  // Nested constant-bound loops keep every index static; the outer loop
  // walks the priority order, the inner one locates that slot.
  always_comb begin
    w_found = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && i_req[i] && (((int'(i_ptr) + k) % NREQ) == i)) begin
          w_found    = 1'b1;
          o_grant[i] = 1'b1;
          o_idx      = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between NREQ requesters
//
// Purpose: accepts one request at a time (valid/ready), drives the shared ALU
//   for one EXEC cycle, and holds result/flags/ID until the consumer accepts.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready [NREQ]     per-requester handshake (ready one-hot or zero)
//   req_op [2*NREQ], req_a/req_b [W*NREQ]  per-requester opcode and operands
//   alu_a/alu_b [W], alu_add/inc/neg/sub   drive to the shared ALU
//   alu_out [W], alu_z, alu_n              ALU results
//   rsp_valid/rsp_ready                    response handshake
//   rsp_result [W], rsp_z, rsp_n, rsp_id [IDW]  captured response
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic              alu_add,
  output logic              alu_inc,
  output logic              alu_neg,
  output logic              alu_sub,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_z,
  output logic              rsp_n,
  output logic [IDW-1:0]    rsp_id
);

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic [1:0]      w_sel_op;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_can_grant;
  logic            w_req_hs;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op = req_op[2*i +: 2];
        w_sel_a  = req_a[W*i +: W];
        w_sel_b  = req_b[W*i +: W];
      end
    end
  end

  // A new request can be taken when idle, or in the same cycle the pending
  // response is accepted, which gives RESP->EXEC back-to-back.
  assign w_can_grant = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
  assign w_req_hs    = w_can_grant && (|w_grant);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req_hs) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) w_next = w_req_hs ? ST_EXEC : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    alu_add   = 1'b0;
    alu_sub   = 1'b0;
    alu_inc   = 1'b0;
    alu_neg   = 1'b0;
    rsp_valid = (r_state == ST_RESP);
    req_ready = w_can_grant ? w_grant : '0;
    if (r_state == ST_EXEC) begin
      case (r_op)
        OP_ADD:  alu_add = 1'b1;
        OP_SUB:  alu_sub = 1'b1;
        OP_INC:  alu_inc = 1'b1;
        default: alu_neg = 1'b1;
      endcase
    end
  end

  // Operands stay on the ALU bus between operations; they only change at a
  // request handshake, i.e. on entry to EXEC.
  assign alu_a = r_a;
  assign alu_b = r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= IDW'(NREQ - 1);
      r_id       <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      rsp_result <= '0;
      rsp_z      <= 1'b0;
      rsp_n      <= 1'b0;
      rsp_id     <= '0;
    end else begin
      if (w_req_hs) begin
        r_op  <= w_sel_op;
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_id  <= w_idx;
        r_ptr <= w_idx;
      end
      if (r_state == ST_EXEC) begin
        rsp_result <= alu_out;
        rsp_z      <= alu_z;
        rsp_n      <= alu_n;
        rsp_id     <= r_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU partner
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op = '0;
  logic [W*NREQ-1:0] req_a = '0;
  logic [W*NREQ-1:0] req_b = '0;
  logic [W-1:0]      alu_a, alu_b;
  logic              alu_add, alu_inc, alu_neg, alu_sub;
  logic [W-1:0]      alu_out;
  logic              alu_z, alu_n;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [W-1:0]      rsp_result;
  logic              rsp_z, rsp_n;
  logic [IDW-1:0]    rsp_id;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_add(alu_add), .alu_inc(alu_inc), .alu_neg(alu_neg), .alu_sub(alu_sub),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_id(rsp_id)
  );

  // Partner ALU
  always_comb begin
    alu_out = '0;
    if (alu_add)      alu_out = alu_a + alu_b;
    else if (alu_sub) alu_out = alu_a - alu_b;
    else if (alu_inc) alu_out = alu_a + 32'd1;
    else if (alu_neg) alu_out = 32'd0 - alu_a;
    alu_z = (alu_out == '0);
    alu_n = alu_out[W-1];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a + 32'd1;
      default: return 32'd0 - a;
    endcase
  endfunction

  // Reference model: phase 0 = free, 1 = ALU busy, 2 = response pending
  int          m_phase = 0;
  int          m_last  = NREQ - 1;
  int          m_id    = 0;
  int          m_win;
  logic [1:0]  m_op  = '0;
  logic [31:0] m_a   = '0;
  logic [31:0] m_b   = '0;
  logic [31:0] m_res = '0;
  logic [NREQ-1:0] m_ready;
  logic [3:0]  m_ctrl;

  function automatic int winner(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_last = NREQ - 1; m_id = 0;
      m_op = '0; m_a = '0; m_b = '0; m_res = '0;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_ctrl", 64'({alu_add, alu_sub, alu_inc, alu_neg}), 64'd0);
      chk("rst_rsp", 64'({rsp_result, rsp_z, rsp_n, rsp_id}), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
    end else begin
      m_win = (m_phase == 0 || (m_phase == 2 && rsp_ready)) ? winner(req_valid, m_last) : -1;
      m_ready = '0;
      if (m_win >= 0) m_ready[m_win] = 1'b1;
      m_ctrl = 4'b0000;
      if (m_phase == 1) m_ctrl = 4'b1000 >> m_op;
      chk("m_ready", 64'(req_ready), 64'(m_ready));
      chk("m_ctrl", 64'({alu_add, alu_sub, alu_inc, alu_neg}), 64'(m_ctrl));
      chk("m_alu_ab", {alu_a, alu_b}, {m_a, m_b});
      chk("m_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase == 2) begin
        chk("m_result", 64'(rsp_result), 64'(m_res));
        chk("m_flags", 64'({rsp_z, rsp_n}), 64'({m_res == 32'd0, m_res[31]}));
        chk("m_id", 64'(rsp_id), 64'(m_id));
      end
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && rsp_ready) m_phase = 0;
      if (m_win >= 0) begin
        m_op    = req_op[2*m_win +: 2];
        m_a     = req_a[W*m_win +: W];
        m_b     = req_b[W*m_win +: W];
        m_res   = golden(m_op, m_a, m_b);
        m_id    = m_win;
        m_last  = m_win;
        m_phase = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input string tag, input int r, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic z, input logic n,
                        input logic [3:0] ctrl);
    bit got;
    req_valid[r] = 1'b1;
    req_op[2*r +: 2] = op;
    req_a[W*r +: W] = a;
    req_b[W*r +: W] = b;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = req_ready[r];
    end
    chk({tag, "_grant"}, 64'(got), 64'd1);
    step();
    req_valid[r] = 1'b0;
    req_a[W*r +: W] = ~a;
    @(negedge clk);
    chk({tag, "_exec_ctrl"}, 64'({alu_add, alu_sub, alu_inc, alu_neg}), 64'(ctrl));
    chk({tag, "_exec_novalid"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_result"}, 64'(rsp_result), 64'(res));
    chk({tag, "_zn"}, 64'({rsp_z, rsp_n}), 64'({z, n}));
    chk({tag, "_id"}, 64'(rsp_id), 64'(r));
    step();
  endtask

  int gid[$];
  int gcyc[$];
  bit got;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic ADD, overflow to zero, signed overflow
    do_req("add",  0, 2'b00, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 4'b1000);
    do_req("wrap", 1, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 4'b1000);
    do_req("ovf",  1, 2'b00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 4'b1000);

    // Each opcode from requester 0
    do_req("sub",  0, 2'b01, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 4'b0100);
    do_req("inc",  0, 2'b10, 32'd41, 32'd9, 32'd42, 1'b0, 1'b0, 4'b0010);
    do_req("neg",  0, 2'b11, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 4'b0001);
    do_req("subz", 0, 2'b01, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 4'b0100);

    // Contention from reset: grants 0,1,0,1 every 2 cycles
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    req_op = 4'b0000;
    req_a = {32'd2, 32'd1};
    req_b = {32'd20, 32'd10};
    req_valid = 2'b11;
    for (int c = 0; c < 30 && gid.size() < 4; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gid.push_back(req_ready[1] ? 1 : 0);
        gcyc.push_back(c);
      end
    end
    step();
    req_valid = '0;
    chk("rr_count", 64'(gid.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", 64'(gid.size() > k ? gid[k] : -1), 64'(k % 2));
      if (k > 0) chk("rr_spacing", 64'(gcyc.size() > k ? gcyc[k] - gcyc[k-1] : -1), 64'd2);
    end
    step(); step(); step();

    // Backpressure with a waiting second requester
    rsp_ready = 1'b0;
    req_op[1:0] = 2'b01; req_a[31:0] = 32'd100; req_b[31:0] = 32'd1;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = req_ready[0];
    end
    chk("bp_grant0", 64'(got), 64'd1);
    step();
    req_valid = 2'b10;
    req_op[3:2] = 2'b00; req_a[63:32] = 32'd4; req_b[63:32] = 32'd4;
    @(negedge clk);
    chk("bp_exec_ready", 64'(req_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_result", 64'(rsp_result), 64'd99);
      chk("bp_hold_id", 64'(rsp_id), 64'd0);
      chk("bp_hold_ready", 64'(req_ready), 64'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 64'(req_ready), 64'b10);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_exec", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("bp_next_valid", 64'(rsp_valid), 64'd1);
    chk("bp_next_result", 64'(rsp_result), 64'd8);
    chk("bp_next_id", 64'(rsp_id), 64'd1);
    step();

    // Reset during EXEC aborts the operation
    req_op[1:0] = 2'b00; req_a[31:0] = 32'd1; req_b[31:0] = 32'd1;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = req_ready[0];
    end
    chk("abort_grant", 64'(got), 64'd1);
    step();
    req_valid = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", 64'({alu_add, alu_sub, alu_inc, alu_neg}), 64'd0);
    chk("abort_valid", 64'(rsp_valid), 64'd0);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("abort_first_win", 64'(req_ready), 64'b01);
    step();
    req_valid = '0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
